// File: rtl/mdu_pkg.sv
// mdu_pkg: op and FSM encodings shared by the sequential multiply/divide unit.
// Signed MULT/DIV support is selected by the MULTDIV_SIGNED_EN macro in multdiv_seq.
package mdu_pkg;

    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_div(op_e o);
        return (o == DIV) || (o == DIVU);
    endfunction

    function automatic logic is_signed(op_e o);
        return (o == MULT) || (o == DIV);
    endfunction

endpackage

// File: rtl/multdiv_seq_condneg.sv
// condneg: combinational conditional two's-complement negate.
// Used for operand magnitudes and for signed result fixup.
module condneg #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    assign y = neg ? ((~x) + WIDTH'(1)) : x;

endmodule

// File: rtl/multdiv_seq.sv
// multdiv_seq: one-bit-per-cycle shift-add multiplier / restoring divider.
// Define MULTDIV_SIGNED_EN for signed MULT/DIV; otherwise every op is unsigned.
module multdiv_seq
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             we,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             divzero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state;
    state_e           state_n;
    logic [CW-1:0]    count;
    op_e              op_q;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic             dz;
    logic             neg_s;
    logic             neg_r;

    op_e              op_in;
    logic             sgn_in;
    logic             sa;
    logic             sb;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   acc_m;
    logic [WIDTH-1:0] q_m;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH:0]   acc_d;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH:0]   acc_n;
    logic [WIDTH-1:0] q_n;

    logic [2*WIDTH-1:0] prod_f;
    logic [WIDTH-1:0]   quot_f;
    logic [WIDTH-1:0]   rem_src;
    logic [WIDTH-1:0]   rem_f;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign op_in = op_e'(op);

`ifdef MULTDIV_SIGNED_EN
    assign sgn_in = is_signed(op_in);
`else
    assign sgn_in = 1'b0;
`endif

    assign sa     = sgn_in & a[WIDTH-1];
    assign sb     = sgn_in & b[WIDTH-1];
    assign accept = (state != RUN) & start & ~flush;
    assign last   = (count == LAST);

    condneg #(.WIDTH(WIDTH)) u_mag_a (.neg(sa), .x(a), .y(mag_a));
    condneg #(.WIDTH(WIDTH)) u_mag_b (.neg(sb), .x(b), .y(mag_b));

    // Multiply: acc:q is the running product, q shifts out the multiplier.
    assign sum   = q[0] ? (acc + {1'b0, d}) : acc;
    assign acc_m = {1'b0, sum[WIDTH:1]};
    assign q_m   = {sum[0], q[WIDTH-1:1]};

    // Divide: acc holds the partial remainder, q shifts dividend -> quotient.
    assign shifted = {acc[WIDTH-1:0], q[WIDTH-1]};
    assign diff    = shifted - {1'b0, d};
    assign ge      = ~diff[WIDTH];
    assign acc_d   = {1'b0, ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]};
    assign q_d     = {q[WIDTH-2:0], ge};

    // A zero divisor freezes the datapath so q still holds |a| at the end.
    always_comb begin
        acc_n = acc_m;
        q_n   = q_m;
        if (is_div(op_q)) begin
            if (dz) begin
                acc_n = acc;
                q_n   = q;
            end else begin
                acc_n = acc_d;
                q_n   = q_d;
            end
        end
    end

    assign rem_src = dz ? q_n : acc_n[WIDTH-1:0];

    condneg #(.WIDTH(2*WIDTH)) u_fix_p (
        .neg (neg_s),
        .x   ({acc_n[WIDTH-1:0], q_n}),
        .y   (prod_f)
    );
    condneg #(.WIDTH(WIDTH)) u_fix_q (.neg(neg_s), .x(q_n), .y(quot_f));
    condneg #(.WIDTH(WIDTH)) u_fix_r (.neg(neg_r), .x(rem_src), .y(rem_f));

    always_comb begin
        res_hi = prod_f[2*WIDTH-1:WIDTH];
        res_lo = prod_f[WIDTH-1:0];
        if (is_div(op_q)) begin
            res_hi = rem_f;
            res_lo = dz ? '1 : quot_f;
        end
    end

    always_comb begin
        state_n = state;
        if (flush) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE:    state_n = accept ? RUN : IDLE;
                RUN:     state_n = last ? DONE : RUN;
                DONE:    state_n = accept ? RUN : IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
            op_q  <= MULTU;
            acc   <= '0;
            q     <= '0;
            d     <= '0;
            dz    <= 1'b0;
            neg_s <= 1'b0;
            neg_r <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                op_q  <= op_in;
                count <= '0;
                acc   <= '0;
                q     <= is_div(op_in) ? mag_a : mag_b;
                d     <= is_div(op_in) ? mag_b : mag_a;
                dz    <= is_div(op_in) & (b == '0);
                neg_s <= sa ^ sb;
                neg_r <= sa;
            end else if (state == RUN) begin
                acc   <= acc_n;
                q     <= q_n;
                count <= count + CW'(1);
                if (last && !flush) begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
            end
        end
    end

    assign busy    = (state == RUN);
    assign done    = (state == DONE);
    assign we      = done;
    assign divzero = done & dz;

endmodule
